lc4_div_seq: RTL

Multi-cycle sequencer for the LC4 DIV and MOD operations, which the single-cycle ALU does not complete. It accepts an operation tagged with its decoded `alu_ctl` code and runs an unsigned restoring division, one quotient bit per cycle. It returns the quotient (DIV) or remainder (MOD) over a valid/ready handshake. It sits beside the execute-stage ALU; the pipeline control holds execute while `o_in_ready` is low.

---
 rtl/lc4_alu_pkg.sv | 17 +
 rtl/lc4_div_step.sv | 24 ++
 rtl/lc4_div_seq.sv | 131 +++++++++++++
 3 files changed

// File: rtl/lc4_alu_pkg.sv
// Shared LC4 ALU definitions: alu_ctl codes, divider FSM states, counter sizing.
package lc4_alu_pkg;

    localparam logic [15:0] ALU_CTL_DIV = 16'd3;
    localparam logic [15:0] ALU_CTL_MOD = 16'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    function automatic int cnt_width(input int w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/lc4_div_step.sv
// One restoring-division iteration: shift {rem, quo} left, try subtracting the divisor.
module lc4_div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;
    logic             negative;

    // One extra bit above the shifted remainder makes the borrow explicit.
    assign shifted  = {rem_in, quo_in[WIDTH-1]};
    assign trial    = shifted - {2'b00, divisor};
    assign negative = trial[WIDTH+1];

    assign rem_out  = negative ? shifted[WIDTH:0] : trial[WIDTH:0];
    assign quo_out  = {quo_in[WIDTH-2:0], ~negative};

endmodule

// File: rtl/lc4_div_seq.sv
// Multi-cycle LC4 DIV/MOD sequencer (unsigned restoring division, one bit per cycle).
// Optional LC4_DIV_EARLY_EXIT_EN: trivial operands (divisor 0 or dividend < divisor) finish in one cycle.
module lc4_div_seq
    import lc4_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [15:0]      i_alu_ctl,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    input  logic             i_flush,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_result,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder
);

    localparam int CNT_W = cnt_width(WIDTH);

    div_state_t       state_reg, state_next;
    logic [CNT_W-1:0] count_reg;
    logic             is_mod_reg;
    logic [WIDTH-1:0] divisor_reg;
    logic [WIDTH-1:0] quo_reg;
    logic [WIDTH:0]   rem_reg;
    logic [WIDTH-1:0] quo_step;
    logic [WIDTH:0]   rem_step;
    logic             accept;
    logic             finish;
    logic             early;
    logic [WIDTH-1:0] fin_quo;
    logic [WIDTH-1:0] fin_rem;

`ifdef LC4_DIV_EARLY_EXIT_EN
    logic early_reg;
    assign early = early_reg;
`else
    assign early = 1'b0;
`endif

    lc4_div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_reg),
        .quo_in  (quo_reg),
        .divisor (divisor_reg),
        .rem_out (rem_step),
        .quo_out (quo_step)
    );

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state_reg)
            IDLE: if (i_in_valid) begin
                state_next = RUN;
                accept     = 1'b1;
            end
            RUN: if (early || count_reg == CNT_W'(WIDTH - 1)) begin
                state_next = DONE;
                finish     = 1'b1;
            end
            DONE: if (i_out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (i_flush) begin
            state_next = IDLE;
            accept     = 1'b0;
            finish     = 1'b0;
        end
    end

    // Final values: LC4 defines x/0 and x%0 as 0; an early exit still holds the dividend in quo_reg.
    always_comb begin
        fin_quo = quo_step;
        fin_rem = rem_step[WIDTH-1:0];
        if (divisor_reg == '0) begin
            fin_quo = '0;
            fin_rem = '0;
        end else if (early) begin
            fin_quo = '0;
            fin_rem = quo_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            count_reg   <= '0;
            is_mod_reg  <= 1'b0;
            divisor_reg <= '0;
            quo_reg     <= '0;
            rem_reg     <= '0;
            o_result    <= '0;
            o_quotient  <= '0;
            o_remainder <= '0;
`ifdef LC4_DIV_EARLY_EXIT_EN
            early_reg   <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            if (accept) begin
                is_mod_reg  <= (i_alu_ctl == ALU_CTL_MOD);
                divisor_reg <= i_divisor;
                quo_reg     <= i_dividend;
                rem_reg     <= '0;
                count_reg   <= '0;
`ifdef LC4_DIV_EARLY_EXIT_EN
                early_reg   <= (i_divisor == '0) || (i_dividend < i_divisor);
`endif
            end else if (state_reg == RUN && !i_flush) begin
                quo_reg   <= quo_step;
                rem_reg   <= rem_step;
                count_reg <= count_reg + 1'b1;
            end
            if (finish) begin
                o_quotient  <= fin_quo;
                o_remainder <= fin_rem;
                o_result    <= is_mod_reg ? fin_rem : fin_quo;
            end
        end
    end

    assign o_in_ready  = (state_reg == IDLE);
    assign o_out_valid = (state_reg == DONE);

endmodule
